game_reg_bank: RTL and testbench

GAME_REG_BANK -- requirements
Module: game_reg_bank

---
 rtl/game_reg_bank.sv | 234 +++++++++++++++++++++++
 tb/tb_game_reg_bank.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_reg_bank.sv
// game_reg_bank: CPU-visible register bank for a small game engine.
// Holds the sprite field table and a frame-lock register that controls
// vblank snapshots into sprite_disp. Also holds a saturating score counter
// and a few read-only status inputs.
// Optional feature macro: SCORE_BCD_EN
//   - Defined: a sequential binary-to-BCD converter drives score_bcd.
//   - Undefined: SCORE_DISP is a plain read/write register.
module game_reg_bank #(
    parameter int NUM_SPRITES = 5,
    parameter int FIELDS      = 6,
    parameter int FIELD_W     = 8,
    parameter int SCORE_W     = 16,
    parameter int BCD_DIGITS  = 5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [5:0]                            reg_addr,
    input  logic [15:0]                           in,
    input  logic                                  we,
    output logic [15:0]                           out,
    input  logic                                  map_data,
    input  logic [1:0]                            player_rot,
    input  logic [5:0]                            frame,
    input  logic                                  pellet_data,
    input  logic                                  vblank,
    output logic                                  frame_done,
    output logic [NUM_SPRITES*FIELDS*FIELD_W-1:0] sprite_disp,
    output logic [4*BCD_DIGITS-1:0]               score_bcd,
    output logic                                  bcd_busy
);

    localparam int NUM_FIELDS = NUM_SPRITES * FIELDS;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [5:0] ADDR_LOCK      = 6'd32;
    localparam logic [5:0] ADDR_SCORE     = 6'd33;
    localparam logic [5:0] ADDR_SCORE_ADD = 6'd34;
    localparam logic [5:0] ADDR_SCORE_DSP = 6'd35;
    localparam logic [5:0] ADDR_MAP       = 6'd48;
    localparam logic [5:0] ADDR_ROT       = 6'd49;
    localparam logic [5:0] ADDR_FRAME     = 6'd50;
    localparam logic [5:0] ADDR_PELLET    = 6'd51;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Parameter sanity: the sprite table must fit below the LOCK address.
    // The BCD width must also hold the largest score.
    generate
        if (NUM_FIELDS < 1 || NUM_FIELDS > 32) begin : g_bad_fields
            $error("game_reg_bank: NUM_SPRITES*FIELDS must be 1..32");
        end
        if (FIELD_W < 1 || FIELD_W > 16) begin : g_bad_field_w
            $error("game_reg_bank: FIELD_W must be 1..16");
        end
        if (SCORE_W < 1 || SCORE_W > 16) begin : g_bad_score_w
            $error("game_reg_bank: SCORE_W must be 1..16");
        end
        if ((64'd10 ** BCD_DIGITS) <= ((64'd1 << SCORE_W) - 64'd1)) begin : g_bad_bcd
            $error("game_reg_bank: BCD_DIGITS too small for SCORE_W");
        end
    endgenerate

    logic [7:0]                    lock_reg;
    logic                          frame_done_reg;
    logic                          capture;
    logic [NUM_FIELDS*FIELD_W-1:0] fields_flat;
    logic [SCORE_W-1:0]            score_reg;
    logic [SCORE_W-1:0]            score_next;
    logic [16:0]                   sum_wide;
    logic [15:0]                   disp_read;

    // Lock is sampled before any same-edge write, so a write to LOCK in the
    // vblank cycle only affects the next frame.
    assign capture    = vblank && (lock_reg == 8'd0);
    assign frame_done = frame_done_reg;

    // Each sprite field has its own live register and snapshot register.
    // Non-blocking update means a same-edge write is not yet in the snapshot.
    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            logic [FIELD_W-1:0] val_reg;
            logic [FIELD_W-1:0] snap_reg;

            // live field write and vblank snapshot of that field
            always_ff @(posedge clk) begin
                if (reset) begin
                    val_reg  <= '0;
                    snap_reg <= '0;
                end else begin
                    if (we && reg_addr == 6'(gi)) begin
                        val_reg <= in[FIELD_W-1:0];
                    end
                    if (capture) begin
                        snap_reg <= val_reg;
                    end
                end
            end

            assign fields_flat[gi*FIELD_W +: FIELD_W] = val_reg;
            assign sprite_disp[gi*FIELD_W +: FIELD_W] = snap_reg;
        end
    endgenerate

    // LOCK register and the one-cycle snapshot-taken pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_reg       <= 8'd0;
            frame_done_reg <= 1'b0;
        end else begin
            if (we && reg_addr == ADDR_LOCK) begin
                lock_reg <= in[7:0];
            end
            frame_done_reg <= capture;
        end
    end

    // The 17-bit sum cannot overflow, so saturation is a single compare.
    assign sum_wide = 17'(score_reg) + 17'(in);

    // next score value: direct load or saturating add
    always_comb begin
        score_next = score_reg;
        if (we && reg_addr == ADDR_SCORE) begin
            score_next = in[SCORE_W-1:0];
        end else if (we && reg_addr == ADDR_SCORE_ADD) begin
            if (sum_wide > 17'(SCORE_MAX)) begin
                score_next = SCORE_MAX;
            end else begin
                score_next = sum_wide[SCORE_W-1:0];
            end
        end
    end

    // score register
    always_ff @(posedge clk) begin
        if (reset) begin
            score_reg <= '0;
        end else begin
            score_reg <= score_next;
        end
    end

`ifdef SCORE_BCD_EN
    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] bin_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   score_bcd_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;

    // add-3 correction of every digit before each shift
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // The top adjusted bit is always zero given the digit-count check.
    assign bcd_shift = BCD_W'({bcd_adj, bin_reg[SCORE_W-1]});

    // Double-dabble sequencer. Any score change restarts from the new value;
    // the previous result stays visible until the new one is complete.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_reg       <= '0;
            bcd_reg       <= '0;
            score_bcd_reg <= '0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
        end else if (score_next != score_reg) begin
            bin_reg  <= score_next;
            bcd_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            bcd_reg <= bcd_shift;
            bin_reg <= bin_reg << 1;
            if (cnt_reg == CNT_W'(SCORE_W - 1)) begin
                busy_reg      <= 1'b0;
                score_bcd_reg <= bcd_shift;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign score_bcd = score_bcd_reg;
    assign bcd_busy  = busy_reg;
    assign disp_read = 16'(score_bcd_reg);
`else
    logic [15:0] disp_reg;

    // plain CPU-owned display register
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_reg <= 16'd0;
        end else if (we && reg_addr == ADDR_SCORE_DSP) begin
            disp_reg <= in;
        end
    end

    assign score_bcd = BCD_W'(disp_reg);
    assign bcd_busy  = 1'b0;
    assign disp_read = disp_reg;
`endif

    // combinational read mux; unmapped addresses read zero
    always_comb begin
        out = 16'd0;
        case (reg_addr)
            ADDR_LOCK:      out = 16'(lock_reg);
            ADDR_SCORE:     out = 16'(score_reg);
            ADDR_SCORE_ADD: out = 16'd0;
            ADDR_SCORE_DSP: out = disp_read;
            ADDR_MAP:       out = 16'(map_data);
            ADDR_ROT:       out = 16'(player_rot);
            ADDR_FRAME:     out = 16'(frame);
            ADDR_PELLET:    out = 16'(pellet_data);
            default: begin
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    if (reg_addr == 6'(i)) begin
                        out = 16'(fields_flat[i*FIELD_W +: FIELD_W]);
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_game_reg_bank.sv
// tb_game_reg_bank: directed scoreboard bench for game_reg_bank.
// Stimulus queues expected values and raises sample_req.
// A separate monitor pops every queued item at the falling edge and compares.
// Build with SCORE_BCD_EN defined to exercise the BCD converter.
module tb_game_reg_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic [5:0]   reg_addr;
    logic [15:0]  in;
    logic         we;
    logic [15:0]  out;
    logic         map_data;
    logic [1:0]   player_rot;
    logic [5:0]   frame;
    logic         pellet_data;
    logic         vblank;
    logic         frame_done;
    logic [239:0] sprite_disp;
    logic [19:0]  score_bcd;
    logic         bcd_busy;

    logic [15:0]  out4;
    logic         frame_done4;
    logic [119:0] sprite_disp4;
    logic [19:0]  score_bcd4;
    logic         bcd_busy4;

    game_reg_bank u_dut (
        .clk(clk), .reset(reset), .reg_addr(reg_addr), .in(in), .we(we), .out(out),
        .map_data(map_data), .player_rot(player_rot), .frame(frame),
        .pellet_data(pellet_data), .vblank(vblank), .frame_done(frame_done),
        .sprite_disp(sprite_disp), .score_bcd(score_bcd), .bcd_busy(bcd_busy)
    );

    game_reg_bank #(.FIELD_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .reg_addr(reg_addr), .in(in), .we(we), .out(out4),
        .map_data(map_data), .player_rot(player_rot), .frame(frame),
        .pellet_data(pellet_data), .vblank(vblank), .frame_done(frame_done4),
        .sprite_disp(sprite_disp4), .score_bcd(score_bcd4), .bcd_busy(bcd_busy4)
    );

    always #5 clk = ~clk;

    typedef enum int {K_OUT, K_OUT4, K_FD, K_DISP, K_BUSY, K_BCD} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t       exp_q[$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic        sample_req = 1'b0;
    item_t       mon_it;
    logic [31:0] mon_act;

    // monitor: compare every queued expectation when a sample is requested
    always @(negedge clk) begin
        if (sample_req) begin
            while (exp_q.size() > 0) begin
                mon_it = exp_q.pop_front();
                case (mon_it.kind)
                    K_OUT:   mon_act = {16'd0, out};
                    K_OUT4:  mon_act = {16'd0, out4};
                    K_FD:    mon_act = {31'd0, frame_done};
                    K_DISP:  mon_act = sprite_disp[31:0];
                    K_BUSY:  mon_act = {31'd0, bcd_busy};
                    default: mon_act = {12'd0, score_bcd};
                endcase
                n_vec++;
                if (mon_act !== mon_it.exp) begin
                    n_miss++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", mon_it.name, mon_act, mon_it.exp);
                end else begin
                    $display("ok   %s = 0x%0h", mon_it.name, mon_act);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(kind_t k, logic [31:0] v, string nm);
        exp_q.push_back('{kind: k, exp: v, name: nm});
    endtask

    task automatic check_now();
        sample_req = 1'b1;
        @(negedge clk);
        #1;
        sample_req = 1'b0;
    endtask

    task automatic wr(logic [5:0] a, logic [15:0] d);
        reg_addr = a;
        in       = d;
        we       = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd_chk(logic [5:0] a, logic [15:0] v, string nm);
        reg_addr = a;
        expect_val(K_OUT, {16'd0, v}, nm);
        check_now();
    endtask

    task automatic vblank_pulse();
        vblank = 1'b1;
        cyc();
        vblank = 1'b0;
    endtask

`ifdef SCORE_BCD_EN
    task automatic busy_run(string nm);
        for (int k = 1; k <= 16; k++) begin
            expect_val(K_BUSY, 32'd1, nm);
            check_now();
            cyc();
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; vblank = 1'b1; we = 1'b1; reg_addr = 6'd0; in = 16'h0055;
        map_data = 1'b0; player_rot = 2'd0; frame = 6'd0; pellet_data = 1'b0;
        repeat (3) cyc();
        reset = 1'b0; vblank = 1'b0; we = 1'b0;

        // reset state; reset won over the simultaneous write and vblank
        reg_addr = 6'd0;
        expect_val(K_OUT,  32'd0, "reset_field0");
        expect_val(K_OUT4, 32'd0, "reset_field0_w4");
        expect_val(K_FD,   32'd0, "reset_frame_done");
        expect_val(K_DISP, 32'd0, "reset_sprite_disp");
        expect_val(K_BUSY, 32'd0, "reset_bcd_busy");
        expect_val(K_BCD,  32'd0, "reset_score_bcd");
        check_now();
        rd_chk(6'd32, 16'h0000, "reset_lock");

        // sprite field write/read, truncation in the 4-bit instance
        wr(6'd7, 16'h00A5);
        rd_chk(6'd7, 16'h00A5, "field7");
        expect_val(K_OUT4, 32'h5, "field7_w4");
        check_now();
        wr(6'd8, 16'h00FF);
        rd_chk(6'd8, 16'h00FF, "field8");
        expect_val(K_OUT4, 32'hF, "field8_w4");
        check_now();
        wr(6'd29, 16'hAB3C);
        rd_chk(6'd29, 16'h003C, "field29_last");
        wr(6'd30, 16'h0077);
        rd_chk(6'd30, 16'h0000, "addr30_unmapped");

        // unlocked snapshot
        wr(6'd0, 16'h0012);
        vblank_pulse();
        expect_val(K_FD,   32'd1,  "snap_frame_done");
        expect_val(K_DISP, 32'h12, "snap_disp");
        check_now();
        cyc();
        expect_val(K_FD, 32'd0, "snap_frame_done_drop");
        check_now();

        // locked frame: no capture, no pulse
        wr(6'd32, 16'h0001);
        rd_chk(6'd32, 16'h0001, "lock_read");
        wr(6'd0, 16'h0034);
        vblank_pulse();
        expect_val(K_FD,   32'd0,  "locked_frame_done");
        expect_val(K_DISP, 32'h12, "locked_disp_hold");
        check_now();
        cyc();
        expect_val(K_FD, 32'd0, "locked_no_deferred");
        check_now();

        // write to a field on the capturing edge: snapshot keeps the old value
        wr(6'd32, 16'h0000);
        reg_addr = 6'd0; in = 16'h0056; we = 1'b1; vblank = 1'b1;
        cyc();
        we = 1'b0; vblank = 1'b0;
        expect_val(K_FD,   32'd1,  "same_edge_frame_done");
        expect_val(K_DISP, 32'h34, "same_edge_disp_prewrite");
        check_now();
        rd_chk(6'd0, 16'h0056, "same_edge_field0");

        // LOCK written on the vblank edge: old LOCK (0) decides
        reg_addr = 6'd32; in = 16'h0005; we = 1'b1; vblank = 1'b1;
        cyc();
        we = 1'b0; vblank = 1'b0;
        expect_val(K_FD,   32'd1,  "lock_edge_frame_done");
        expect_val(K_DISP, 32'h56, "lock_edge_disp");
        check_now();
        rd_chk(6'd32, 16'h0005, "lock_value5");
        wr(6'd32, 16'h0100);
        rd_chk(6'd32, 16'h0000, "lock_8bit_trunc");

        // score load and saturating add
        wr(6'd33, 16'd65530);
        rd_chk(6'd33, 16'hFFFA, "score_load");
        wr(6'd34, 16'd10);
        rd_chk(6'd33, 16'hFFFF, "score_add_sat");
        wr(6'd34, 16'd1);
        rd_chk(6'd33, 16'hFFFF, "score_add_sat_hold");
        rd_chk(6'd34, 16'h0000, "score_add_reads0");
        wr(6'd33, 16'd100);
        wr(6'd34, 16'd23);
        rd_chk(6'd33, 16'd123, "score_add_plain");
        wr(6'd34, 16'hFFFF);
        rd_chk(6'd33, 16'hFFFF, "score_add_big_sat");

`ifdef SCORE_BCD_EN
        // conversion of 1234: 16 busy cycles, then result
        wr(6'd33, 16'd1234);
        busy_run("bcd_busy_1234");
        reg_addr = 6'd35;
        expect_val(K_BUSY, 32'd0,      "bcd_done_busy");
        expect_val(K_BCD,  32'h01234,  "bcd_1234");
        expect_val(K_OUT,  32'h1234,   "score_disp_1234");
        check_now();
        wr(6'd35, 16'hBEEF);
        rd_chk(6'd35, 16'h1234, "score_disp_write_ignored");

        // restart on SCORE_ADD in cycle 5 of a conversion
        wr(6'd33, 16'd0);
        wr(6'd33, 16'd1234);
        repeat (4) cyc();
        wr(6'd34, 16'd1);
        expect_val(K_BCD, 32'h01234, "bcd_hold_during_restart");
        check_now();
        busy_run("bcd_busy_restart");
        expect_val(K_BUSY, 32'd0,     "bcd_restart_done_busy");
        expect_val(K_BCD,  32'h01235, "bcd_1235");
        check_now();

        // reset mid-conversion with vblank
        wr(6'd33, 16'd999);
        cyc();
        cyc();
        expect_val(K_BUSY, 32'd1, "busy_before_reset");
        check_now();
`else
        // plain SCORE_DISP register
        wr(6'd35, 16'hBEEF);
        rd_chk(6'd35, 16'hBEEF, "score_disp_rw");
        expect_val(K_BCD,  32'h0BEEF, "score_bcd_zext");
        expect_val(K_BUSY, 32'd0,     "bcd_busy_const");
        check_now();
        wr(6'd33, 16'd77);
        expect_val(K_BUSY, 32'd0, "bcd_busy_after_score");
        check_now();
`endif
        reset = 1'b1; vblank = 1'b1;
        cyc();
        reset = 1'b0; vblank = 1'b0;
        reg_addr = 6'd33;
        expect_val(K_OUT,  32'd0, "mid_reset_score");
        expect_val(K_BUSY, 32'd0, "mid_reset_busy");
        expect_val(K_BCD,  32'd0, "mid_reset_bcd");
        expect_val(K_FD,   32'd0, "mid_reset_frame_done");
        expect_val(K_DISP, 32'd0, "mid_reset_disp");
        check_now();
        cyc();
        expect_val(K_BUSY, 32'd0, "mid_reset_busy_after");
        expect_val(K_FD,   32'd0, "mid_reset_no_frame_done");
        check_now();
        rd_chk(6'd35, 16'h0000, "mid_reset_score_disp");

        // external status inputs and unmapped addresses
        frame = 6'h2A; map_data = 1'b1; player_rot = 2'd2; pellet_data = 1'b1;
        rd_chk(6'd50, 16'h002A, "status_frame");
        rd_chk(6'd48, 16'h0001, "status_map");
        rd_chk(6'd49, 16'h0002, "status_rot");
        rd_chk(6'd51, 16'h0001, "status_pellet");
        rd_chk(6'd40, 16'h0000, "unmapped_40");
        rd_chk(6'd63, 16'h0000, "unmapped_63");
        wr(6'd40, 16'h1234);
        rd_chk(6'd40, 16'h0000, "unmapped_write_40");

        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
